// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared memory-system types and defaults
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    RET_NONE = 2'b00,
    RET_CPU  = 2'b01,
    RET_PER  = 2'b10
  } ret_t;
  localparam int MAXWAIT_DEF = 4;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one dmemory port between the CPU and a peripheral with a starvation guard
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic [WIDTH-1:0] cpu_memdata,
  output logic             cpu_stall,
  input  logic             per_req,
  input  logic             per_we,
  input  logic [WIDTH-1:0] per_adr,
  input  logic [WIDTH-1:0] per_wdata,
  output logic             per_gnt,
  output logic             per_rvalid,
  output logic [WIDTH-1:0] per_rdata,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_writedata,
  input  logic [WIDTH-1:0] mem_data
);
  logic [3:0]       wait_cnt;
  ret_t             ret;
  logic [WIDTH-1:0] cpu_hold;
  logic             cpu_req;
  logic             cpu_gnt;
  // grant selection, memory port steering and read-return routing; reset silences every output
  always_comb begin
    cpu_req       = cpu_memread | cpu_memwrite;
    cpu_gnt       = !reset && cpu_req && (wait_cnt < 4'(MAXWAIT));
    per_gnt       = !reset && !cpu_gnt && per_req;
    cpu_stall     = !reset && cpu_req && !cpu_gnt;
    mem_write     = cpu_gnt ? cpu_memwrite : (per_gnt && per_we);
    mem_read      = cpu_gnt ? !cpu_memwrite : (per_gnt && !per_we);
    mem_adr       = cpu_gnt ? cpu_adr : per_gnt ? per_adr : '0;
    mem_writedata = cpu_gnt ? cpu_writedata : per_gnt ? per_wdata : '0;
    per_rvalid    = !reset && (ret == RET_PER);
    per_rdata     = per_rvalid ? mem_data : '0;
    cpu_memdata   = reset ? '0 : (ret == RET_CPU) ? mem_data : cpu_hold;
  end
  // starvation counter, owner of the read returning next cycle, and last CPU read value
  always_ff @(posedge clk)
    if (reset) begin
      wait_cnt <= '0;
      ret      <= RET_NONE;
      cpu_hold <= '0;
    end else begin
      wait_cnt <= per_gnt ? '0 : (per_req && wait_cnt < 4'(MAXWAIT)) ? wait_cnt + 4'd1 : wait_cnt;
      ret      <= (cpu_gnt && !cpu_memwrite) ? RET_CPU : (per_gnt && !per_we) ? RET_PER : RET_NONE;
      if (ret == RET_CPU) cpu_hold <= mem_data;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed cases plus randomized traffic against a read-scoreboard reference model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int W  = 32;
  localparam int MW = MAXWAIT_DEF;
  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_memread, cpu_memwrite;
  logic [W-1:0] cpu_adr, cpu_writedata, cpu_memdata;
  logic         cpu_stall;
  logic         per_req, per_we, per_gnt, per_rvalid;
  logic [W-1:0] per_adr, per_wdata, per_rdata;
  logic         mem_read, mem_write;
  logic [W-1:0] mem_adr, mem_writedata, mem_data;
  always #5 clk = ~clk;
  mem_arbiter #(.WIDTH(W), .MAXWAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
    .cpu_memdata(cpu_memdata), .cpu_stall(cpu_stall),
    .per_req(per_req), .per_we(per_we), .per_adr(per_adr), .per_wdata(per_wdata),
    .per_gnt(per_gnt), .per_rvalid(per_rvalid), .per_rdata(per_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_adr(mem_adr),
    .mem_writedata(mem_writedata), .mem_data(mem_data)
  );
  typedef struct {int owner; int cyc;} rd_t;
  rd_t          rd_q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc_no = 0;
  int           m_wait = 0;
  logic [W-1:0] m_hold = '0;
  bit           hold_cpu = 0;
  bit           hold_per = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic settle();
    int   owner;
    bit   cpu, cg, pg;
    rd_t  r;
    @(negedge clk);
    owner = 0;
    while (rd_q.size() > 0 && rd_q[0].cyc < cyc_no - 1) void'(rd_q.pop_front());
    if (rd_q.size() > 0 && rd_q[0].cyc == cyc_no - 1) begin
      r = rd_q.pop_front();
      owner = r.owner;
    end
    if (reset) begin
      chk("rst_stall", cpu_stall, 0);
      chk("rst_per_gnt", per_gnt, 0);
      chk("rst_rvalid", per_rvalid, 0);
      chk("rst_rdata", per_rdata, 0);
      chk("rst_cpu_memdata", cpu_memdata, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_mem_adr", mem_adr, 0);
      chk("rst_mem_wdata", mem_writedata, 0);
      rd_q.delete();
      m_wait = 0;
      m_hold = '0;
      hold_cpu = 0;
      hold_per = 0;
    end else begin
      cpu = cpu_memread || cpu_memwrite;
      cg  = cpu && (m_wait < MW);
      pg  = !cg && per_req;
      chk("cpu_stall", cpu_stall, cpu && !cg);
      chk("per_gnt", per_gnt, pg);
      chk("mem_write", mem_write, cg ? cpu_memwrite : (pg && per_we));
      chk("mem_read", mem_read, cg ? !cpu_memwrite : (pg && !per_we));
      chk("mem_adr", mem_adr, cg ? cpu_adr : pg ? per_adr : '0);
      chk("mem_wdata", mem_writedata, cg ? cpu_writedata : pg ? per_wdata : '0);
      chk("per_rvalid", per_rvalid, owner == 2);
      chk("per_rdata", per_rdata, (owner == 2) ? mem_data : '0);
      chk("cpu_memdata", cpu_memdata, (owner == 1) ? mem_data : m_hold);
      if (owner == 1) m_hold = mem_data;
      if (cg && !cpu_memwrite) rd_q.push_back('{owner: 1, cyc: cyc_no});
      if (pg && !per_we) rd_q.push_back('{owner: 2, cyc: cyc_no});
      m_wait = pg ? 0 : per_req ? ((m_wait + 1 > MW) ? MW : m_wait + 1) : m_wait;
      hold_cpu = cpu && !cg;
      hold_per = per_req && !pg;
    end
  endtask
  task automatic adv();
    @(posedge clk);
    #1;
    cyc_no++;
  endtask
  task automatic idle();
    cpu_memread = 0; cpu_memwrite = 0; cpu_adr = '0; cpu_writedata = '0;
    per_req = 0; per_we = 0; per_adr = '0; per_wdata = '0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1;
    settle(); adv();
    settle(); adv();
    reset = 0;
  endtask
  initial begin
    idle();
    mem_data = '0;
    reset = 1;
    #1;
    do_reset();
    cpu_memread = 1; cpu_adr = 32'h10;
    settle();
    chk("t029_read", mem_read, 1);
    chk("t029_adr", mem_adr, 32'h10);
    chk("t029_stall", cpu_stall, 0);
    adv();
    cpu_memread = 0; mem_data = 32'h5555;
    settle();
    chk("t029_data", cpu_memdata, 32'h5555);
    adv();
    do_reset();
    cpu_memwrite = 1; cpu_adr = 32'h4; cpu_writedata = 32'h77; per_req = 1; per_adr = 32'h8;
    settle();
    chk("t030_per_gnt", per_gnt, 0);
    chk("t030_write", mem_write, 1);
    chk("t030_wdata", mem_writedata, 32'h77);
    adv();
    chk("t030_wait", dut.wait_cnt, 1);
    do_reset();
    per_req = 1; per_we = 1; per_adr = 32'h30; cpu_memread = 1;
    for (int i = 0; i < 7; i++) begin
      cpu_adr = 32'(i);
      settle();
      chk("t031_per_gnt", per_gnt, i == MW);
      chk("t031_stall", cpu_stall, i == MW);
      adv();
      if (i == MW) per_req = 0;
    end
    do_reset();
    cpu_memread = 1; cpu_adr = 32'h40;
    settle(); adv();
    cpu_memread = 0; mem_data = 32'h1234;
    settle(); adv();
    per_req = 1; per_we = 0; per_adr = 32'h20; mem_data = '0;
    settle();
    chk("t032_gnt", per_gnt, 1);
    chk("t032_adr", mem_adr, 32'h20);
    adv();
    per_req = 0; mem_data = 32'hABCD;
    settle();
    chk("t032_rvalid", per_rvalid, 1);
    chk("t032_rdata", per_rdata, 32'hABCD);
    chk("t032_cpu_data", cpu_memdata, 32'h1234);
    adv();
    mem_data = 32'h9999;
    settle();
    chk("t032_cpu_keep", cpu_memdata, 32'h1234);
    adv();
    do_reset();
    per_req = 1; per_we = 0; per_adr = 32'h20;
    settle(); adv();
    per_req = 0; reset = 1; mem_data = 32'hABCD;
    settle();
    chk("t033_rvalid", per_rvalid, 0);
    chk("t033_rdata", per_rdata, 0);
    chk("t033_cpu_data", cpu_memdata, 0);
    adv();
    reset = 0;
    settle();
    chk("t033_after", per_rvalid, 0);
    adv();
    do_reset();
    cpu_memread = 1; cpu_memwrite = 1; cpu_adr = 32'h50; cpu_writedata = 32'h66;
    settle();
    chk("t034_write", mem_write, 1);
    chk("t034_read", mem_read, 0);
    adv();
    chk("t034_ret", dut.ret, RET_NONE);
    idle();
    for (int i = 0; i < 3000; i++) begin
      int k;
      reset = ($urandom_range(99) == 0);
      if (!hold_cpu) begin
        k = $urandom_range(7);
        cpu_memread   = (k < 3) || (k == 5);
        cpu_memwrite  = (k == 3) || (k == 4) || (k == 5);
        cpu_adr       = $urandom;
        cpu_writedata = $urandom;
      end
      if (!hold_per) begin
        per_req   = $urandom_range(1);
        per_we    = $urandom_range(1);
        per_adr   = $urandom;
        per_wdata = $urandom;
      end
      mem_data = $urandom;
      settle();
      adv();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data and address width.
REQ-002 SHALL have parameter MAXWAIT, default 4, the peripheral wait cycles after which the peripheral overrides CPU priority (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports cpu_memread, cpu_memwrite  input  1 each  CPU data-port request strobes.
REQ-006 SHALL have ports cpu_adr, cpu_writedata  input  WIDTH each  CPU address and write data.
REQ-007 SHALL have ports cpu_memdata  output  WIDTH  and cpu_stall  output  1  CPU read data and CPU hold request.
REQ-008 SHALL have ports per_req, per_we  input  1 each  and per_adr, per_wdata  input  WIDTH each  peripheral (display/button) request.
REQ-009 SHALL have ports per_gnt, per_rvalid  output  1 each  and per_rdata  output  WIDTH  peripheral accept, read-return valid and data.
REQ-010 SHALL have ports mem_read, mem_write  output  1 each, mem_adr, mem_writedata  output  WIDTH each, and mem_data  input  WIDTH  shared dmemory port.

Function
REQ-011 SHALL treat a CPU request as present when cpu_memread or cpu_memwrite is 1; if both are 1, write wins.
REQ-012 SHALL grant combinationally each cycle: CPU if present and wait_cnt < MAXWAIT; else peripheral if per_req; else none.
REQ-013 SHALL, with wait_cnt == MAXWAIT and per_req=1, grant the peripheral even when the CPU request is present.
REQ-014 SHALL drive mem_* from the granted requester (mem_write=per_we or cpu write, mem_read=its read), and all mem_* outputs to 0 when there is no grant.
REQ-015 SHALL assert cpu_stall = CPU request present and CPU not granted; the CPU holds its request until cpu_stall=0.
REQ-016 SHALL assert per_gnt in the cycle the peripheral is granted; the peripheral holds its request until per_gnt=1.
REQ-017 SHALL keep the 4-bit wait_cnt register: cleared on per_gnt; incremented when per_req=1 and per_gnt=0; saturating at MAXWAIT.
REQ-018 SHALL keep a registered return-owner state ret in {NONE, CPU, PER}, loaded each cycle with the owner of a granted read (NONE for writes and idle cycles).
REQ-019 SHALL assume a one-cycle dmemory read latency: mem_data is valid in the cycle after mem_read=1.
REQ-020 SHALL assert per_rvalid=1 with per_rdata=mem_data when ret==PER; otherwise per_rvalid=0 and per_rdata=0.
REQ-021 SHALL drive cpu_memdata=mem_data when ret==CPU, else the cpu_hold register, which captures mem_data whenever ret==CPU; peripheral reads SHALL never alter cpu_memdata.
REQ-022 SHALL allow back-to-back grants with no idle cycle between requesters.
REQ-023 SHALL, after a forced peripheral grant (REQ-013), give the CPU priority again next cycle because wait_cnt has cleared.

Reset
REQ-024 SHALL, while reset=1, force wait_cnt=0, ret=NONE and cpu_hold=0.
REQ-025 SHALL, while reset=1, drive cpu_stall=0, per_gnt=0, per_rvalid=0, per_rdata=0, cpu_memdata=0 and all mem_* outputs to 0.
REQ-026 SHALL discard any read return in flight when reset is asserted mid-operation; no per_rvalid pulse follows reset.

Structure
REQ-027 SHALL place the ret state encoding (NONE=2'b00, CPU=2'b01, PER=2'b10) and the default MAXWAIT in the shared memory-system package.
REQ-028 SHALL be a single module with no sub-modules, instantiated between mips and dmemory in the top level.

Verification
REQ-029 SHALL pass this case: CPU read of 0x10 alone -> mem_read=1, mem_adr=0x10, cpu_stall=0; next cycle cpu_memdata=mem_data.
REQ-030 SHALL pass this case: CPU write and per_req together with wait_cnt=0 -> CPU granted, per_gnt=0, wait_cnt=1.
REQ-031 SHALL pass this case: CPU issues continuous requests and per_req=1, MAXWAIT=4 -> per_gnt=1 in the 5th cycle; cpu_stall=1 in that cycle only.
REQ-032 SHALL pass this case: peripheral read of 0x20 returning 0xABCD while cpu_hold=0x1234 -> per_rvalid=1, per_rdata=0xABCD; cpu_memdata stays 0x1234.
REQ-033 SHALL pass this case: reset asserted in the cycle after a peripheral read grant -> per_rvalid=0 and all outputs 0 at the next edge.
REQ-034 SHALL pass this case: cpu_memread=cpu_memwrite=1 -> mem_write=1, mem_read=0, ret=NONE.
